// File: rtl/stream_arb2_sel_pkg.sv
// Shared definitions for the two-source packet-locking stream arbiter:
// FSM state encodings and the default payload width.
package stream_arb2_sel_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

endpackage

// File: rtl/stream_arb2_sel_pick.sv
// Combinational grant for the 2-input arbiter. A locked packet pins the grant
// to its owner; in ARB the source not named by rr_ptr wins a tie.
module rr_pick2
    import stream_arb2_sel_pkg::*;
(
    input  state_e state,
    input  logic   rr_ptr,
    input  logic   in0_valid,
    input  logic   in1_valid,
    output logic   grant
);

    always_comb begin
        grant = 1'b0;
        case (state)
            ST_LOCK0: grant = 1'b0;
            ST_LOCK1: grant = 1'b1;
            default: begin
                if (in0_valid && in1_valid) grant = ~rr_ptr;
                else if (in1_valid)         grant = 1'b1;
                else                        grant = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stream_arb2_sel.sv
// Round-robin 2:1 stream arbiter with packet lock and a registered output
// stage; out_src is the select for the downstream data mux.
module stream_arb2_sel
    import stream_arb2_sel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_src_q, out_src_d;

    logic             grant;
    logic             load_en;
    logic             xfer;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    rr_pick2 u_pick (
        .state     (state_q),
        .rr_ptr    (rr_ptr_q),
        .in0_valid (in0_valid),
        .in1_valid (in1_valid),
        .grant     (grant)
    );

    // The output slot can take a beat when empty or draining this cycle.
    assign load_en   = !out_valid_q || out_ready;
    assign in0_ready = load_en && !grant;
    assign in1_ready = load_en && grant;
    assign xfer      = load_en && (grant ? in1_valid : in0_valid);
    assign sel_data  = grant ? in1_data : in0_data;
    assign sel_last  = grant ? in1_last : in0_last;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant;
            rr_ptr_d    = grant;
            if (sel_last)   state_d = ST_ARB;
            else if (grant) state_d = ST_LOCK1;
            else            state_d = ST_LOCK0;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb2_sel.sv
// Directed bench for stream_arb2_sel: reset, fairness, lock, backpressure,
// locked-idle and reset-mid-packet scenarios with hand-computed expectations.
module tb_stream_arb2_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in0_valid = 1'b0, in0_last = 1'b0;
    logic       in1_valid = 1'b0, in1_last = 1'b0;
    logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
    logic       in0_ready, in1_ready;
    logic       out_valid, out_last, out_src;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    int total = 0;
    int bad   = 0;

    stream_arb2_sel #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic s);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, ".last"},  {31'd0, out_last},  {31'd0, l});
        chk({tag, ".src"},   {31'd0, out_src},   {31'd0, s});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".rdy0"}, {31'd0, in0_ready}, {31'd0, r0});
        chk({tag, ".rdy1"}, {31'd0, in1_ready}, {31'd0, r1});
    endtask

    task automatic src0(input logic v, input logic [7:0] d, input logic l);
        in0_valid = v; in0_data = d; in0_last = l;
    endtask

    task automatic src1(input logic v, input logic [7:0] d, input logic l);
        in1_valid = v; in1_data = d; in1_last = l;
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk_out("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk_rdy("rst_idle", 1'b1, 1'b0);
        src1(1'b1, 8'h5A, 1'b1);
        chk_rdy("rst_only1", 1'b0, 1'b1);
        src1(1'b0, 8'h00, 1'b0);
        #1;

        // fairness: source 0 holds priority out of reset
        src0(1'b1, 8'hA0, 1'b1); src1(1'b1, 8'hB0, 1'b1);
        chk_rdy("fair0", 1'b1, 1'b0);
        step(); chk_out("fair0", 1'b1, 8'hA0, 1'b1, 1'b0);
        src0(1'b1, 8'hA1, 1'b1);
        chk_rdy("fair1", 1'b0, 1'b1);
        step(); chk_out("fair1", 1'b1, 8'hB0, 1'b1, 1'b1);
        src1(1'b1, 8'hB1, 1'b1);
        chk_rdy("fair2", 1'b1, 1'b0);
        step(); chk_out("fair2", 1'b1, 8'hA1, 1'b1, 1'b0);
        src0(1'b0, 8'h00, 1'b0);
        step(); chk_out("fair3", 1'b1, 8'hB1, 1'b1, 1'b1);
        src1(1'b0, 8'h00, 1'b0);
        step(); chk("fair_drain", {31'd0, out_valid}, 32'd0);

        // lock: in0 3-beat packet, in1 waiting
        src0(1'b1, 8'h11, 1'b0); src1(1'b1, 8'hB5, 1'b1);
        chk_rdy("lock0", 1'b1, 1'b0);
        step(); chk_out("lock0", 1'b1, 8'h11, 1'b0, 1'b0);
        src0(1'b1, 8'h12, 1'b0);
        chk_rdy("lock1", 1'b1, 1'b0);
        step(); chk_out("lock1", 1'b1, 8'h12, 1'b0, 1'b0);
        src0(1'b1, 8'h13, 1'b1);
        chk_rdy("lock2", 1'b1, 1'b0);
        step(); chk_out("lock2", 1'b1, 8'h13, 1'b1, 1'b0);
        src0(1'b0, 8'h00, 1'b0);
        chk_rdy("lock_rel", 1'b0, 1'b1);
        step(); chk_out("lock_next", 1'b1, 8'hB5, 1'b1, 1'b1);
        src1(1'b0, 8'h00, 1'b0);
        step();

        // backpressure
        src0(1'b1, 8'h21, 1'b1);
        step(); chk_out("bp_load", 1'b1, 8'h21, 1'b1, 1'b0);
        out_ready = 1'b0;
        src0(1'b1, 8'h22, 1'b1); src1(1'b1, 8'hC1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_rdy("bp_stall", 1'b0, 1'b0);
            step(); chk_out("bp_hold", 1'b1, 8'h21, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        chk_rdy("bp_resume", 1'b0, 1'b1);
        step(); chk_out("bp_next", 1'b1, 8'hC1, 1'b1, 1'b1);
        src1(1'b0, 8'h00, 1'b0);
        chk_rdy("bp_after", 1'b1, 1'b0);
        step(); chk_out("bp_after", 1'b1, 8'h22, 1'b1, 1'b0);
        src0(1'b0, 8'h00, 1'b0);
        step(); chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // locked idle: in1 owns the lock while idle, in0 starves
        src1(1'b1, 8'hD1, 1'b0);
        step(); chk_out("idle_first", 1'b1, 8'hD1, 1'b0, 1'b1);
        src1(1'b0, 8'h00, 1'b0); src0(1'b1, 8'h31, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk_rdy("idle_starve", 1'b0, 1'b1);
            step(); chk("idle_bubble", {31'd0, out_valid}, 32'd0);
        end
        src1(1'b1, 8'hD2, 1'b1);
        chk_rdy("idle_end", 1'b0, 1'b1);
        step(); chk_out("idle_end", 1'b1, 8'hD2, 1'b1, 1'b1);
        src1(1'b0, 8'h00, 1'b0);
        chk_rdy("idle_rel", 1'b1, 1'b0);
        step(); chk_out("idle_rel", 1'b1, 8'h31, 1'b1, 1'b0);
        src0(1'b0, 8'h00, 1'b0);
        step();

        // reset while in1 holds the lock
        src1(1'b1, 8'hE1, 1'b0);
        step(); chk_out("rmid_first", 1'b1, 8'hE1, 1'b0, 1'b1);
        src1(1'b1, 8'hE2, 1'b0); src0(1'b1, 8'h41, 1'b1);
        #1 rst = 1'b1;
        #1 chk_out("rmid_async", 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        chk_rdy("rmid_rel", 1'b1, 1'b0);
        step(); chk_out("rmid_grant", 1'b1, 8'h41, 1'b1, 1'b0);
        src0(1'b0, 8'h00, 1'b0); src1(1'b0, 8'h00, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
